db_event_arbiter: RTL and testbench

- Sits directly after the four-channel debouncer bank (HS, VS, DF_UART, DF_VGA).
- Turns the debounced button levels into discrete press and long-press events.
- Buffers one pending event of each type per button and issues events one at a time to the mode/config logic over a valid/ready handshake.
- Shares the single event channel between buttons with round-robin arbitration.

---
 rtl/db_ctrl_pkg.sv | 28 ++
 rtl/db_btn_tracker.sv | 91 +++++++++
 rtl/db_event_arbiter.sv | 143 ++++++++++++++
 tb/tb_db_event_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/db_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : db_ctrl_pkg
// Description : Shared constants and types for the debounced-button event
//               path. It holds the button index map, the event-type encoding
//               and the arbiter state type.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package db_ctrl_pkg;

  // Button index map, as seen at the debouncer bank outputs
  localparam int BTN_HS      = 0;
  localparam int BTN_VS      = 1;
  localparam int BTN_DF_UART = 2;
  localparam int BTN_DF_VGA  = 3;

  // Event type carried on evt_long
  localparam logic EVT_PRESS = 1'b0;
  localparam logic EVT_LONG  = 1'b1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } arb_state_t;

endpackage : db_ctrl_pkg
`default_nettype wire

// File: rtl/db_btn_tracker.sv
`default_nettype none
// ============================================================================
// Module      : db_btn_tracker
// Description : Per-button event tracker. It detects a rising edge (press)
//               and a hold of LONG_CYCLES high cycles (long press). It keeps
//               one pending bit per event type and flags an overrun when an
//               event arrives while its pending bit is still full.
// Ports       : clk, rst          - clock, async active-high reset
//               level_i           - debounced button level
//               clear_press_i     - arbiter consumed the pending press
//               clear_long_i      - arbiter consumed the pending long press
//               overrun_clr_i     - clear the sticky overrun flag
//               press_pend_o      - press event pending
//               long_pend_o       - long-press event pending
//               overrun_o         - sticky: an event was dropped
// Revision    : 1.0 - initial release
// ============================================================================
module db_btn_tracker #(
  parameter int LONG_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic level_i,
  input  logic clear_press_i,
  input  logic clear_long_i,
  input  logic overrun_clr_i,
  output logic press_pend_o,
  output logic long_pend_o,
  output logic overrun_o
);

  localparam int CW = $clog2(LONG_CYCLES + 1);
  localparam logic [CW-1:0] c_long_cycles = CW'(LONG_CYCLES);
  localparam logic [CW-1:0] c_long_m1     = CW'(LONG_CYCLES - 1);

  logic          prev_q;
  logic [CW-1:0] hold_cnt_q, hold_cnt_d;
  logic          press_pend_q, press_pend_d;
  logic          long_pend_q, long_pend_d;
  logic          overrun_q, overrun_d;

  logic w_rise;
  logic w_long_hit;
  logic w_drop;

  assign w_rise     = level_i & ~prev_q;
  // The counter saturates at LONG_CYCLES, so this matches once per press.
  assign w_long_hit = level_i & (hold_cnt_q == c_long_m1);

  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (!level_i) begin
      hold_cnt_d = '0;
    end else if (hold_cnt_q != c_long_cycles) begin
      hold_cnt_d = hold_cnt_q + CW'(1);
    end
  end

  // A new event and a same-cycle clear leave the bit set, which counts as a
  // refill rather than a drop.
  assign press_pend_d = w_rise | (press_pend_q & ~clear_press_i);
  assign long_pend_d  = w_long_hit | (long_pend_q & ~clear_long_i);

  assign w_drop = (w_rise & press_pend_q & ~clear_press_i)
                | (w_long_hit & long_pend_q & ~clear_long_i);

  // A new drop beats a simultaneous clear request.
  assign overrun_d = w_drop | (overrun_q & ~overrun_clr_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q       <= 1'b0;
      hold_cnt_q   <= '0;
      press_pend_q <= 1'b0;
      long_pend_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      prev_q       <= level_i;
      hold_cnt_q   <= hold_cnt_d;
      press_pend_q <= press_pend_d;
      long_pend_q  <= long_pend_d;
      overrun_q    <= overrun_d;
    end
  end

  assign press_pend_o = press_pend_q;
  assign long_pend_o  = long_pend_q;
  assign overrun_o    = overrun_q;

endmodule : db_btn_tracker
`default_nettype wire

// File: rtl/db_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : db_event_arbiter
// Description : Converts debounced button levels into press / long-press
//               events. It buffers one event of each type per button and
//               issues them one at a time over a valid/ready channel, using
//               round-robin arbitration between buttons.
// Ports       : clk, rst     - clock, async active-high reset
//               btn_level    - debounced button levels
//               evt_ready    - consumer accepts the offered event
//               evt_valid    - event offered
//               evt_id       - index of the originating button
//               evt_long     - 0 = press, 1 = long press
//               overrun      - sticky per-button lost-event flags
//               overrun_clr  - clears all overrun flags
// Revision    : 1.0 - initial release
// ============================================================================
module db_event_arbiter
  import db_ctrl_pkg::*;
#(
  parameter int N_BTN       = 4,
  parameter int LONG_CYCLES = 50_000_000
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [N_BTN-1:0]                      btn_level,
  input  logic                                  evt_ready,
  output logic                                  evt_valid,
  output logic [((N_BTN > 1) ? $clog2(N_BTN) : 1)-1:0] evt_id,
  output logic                                  evt_long,
  output logic [N_BTN-1:0]                      overrun,
  input  logic                                  overrun_clr
);

  localparam int IW = (N_BTN > 1) ? $clog2(N_BTN) : 1;

  arb_state_t          state_q, state_d;
  logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
  logic                evt_valid_q, evt_valid_d;
  logic [IW-1:0]       evt_id_q, evt_id_d;
  logic                evt_long_q, evt_long_d;

  logic [N_BTN-1:0]    w_press_pend;
  logic [N_BTN-1:0]    w_long_pend;
  logic [N_BTN-1:0]    w_req;
  logic [N_BTN-1:0]    w_clr_press;
  logic [N_BTN-1:0]    w_clr_long;
  logic                w_any;
  logic [IW-1:0]       w_sel;
  logic [IW-1:0]       w_idx;

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    db_btn_tracker #(
      .LONG_CYCLES (LONG_CYCLES)
    ) u_tracker (
      .clk           (clk),
      .rst           (rst),
      .level_i       (btn_level[g]),
      .clear_press_i (w_clr_press[g]),
      .clear_long_i  (w_clr_long[g]),
      .overrun_clr_i (overrun_clr),
      .press_pend_o  (w_press_pend[g]),
      .long_pend_o   (w_long_pend[g]),
      .overrun_o     (overrun[g])
    );
  end

  assign w_req = w_press_pend | w_long_pend;

  // Round-robin pick: the first requester at or after rr_ptr, with wrap.
  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    w_idx = '0;
    for (int k = 0; k < N_BTN; k++) begin
      w_idx = IW'((int'(rr_ptr_q) + k) % N_BTN);
      if (!w_any && w_req[w_idx]) begin
        w_any = 1'b1;
        w_sel = w_idx;
      end
    end
  end

  // State register and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      evt_valid_q <= 1'b0;
      evt_id_q    <= '0;
      evt_long_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      evt_valid_q <= evt_valid_d;
      evt_id_q    <= evt_id_d;
      evt_long_q  <= evt_long_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (w_any)     state_d = ST_OFFER;
      ST_OFFER: if (evt_ready) state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    evt_valid_d = evt_valid_q;
    evt_id_d    = evt_id_q;
    evt_long_d  = evt_long_q;
    rr_ptr_d    = rr_ptr_q;
    w_clr_press = '0;
    w_clr_long  = '0;
    case (state_q)
      ST_IDLE: begin
        if (w_any) begin
          evt_valid_d = 1'b1;
          evt_id_d    = w_sel;
          // A pending press is always served before a pending long press.
          evt_long_d  = w_press_pend[w_sel] ? EVT_PRESS : EVT_LONG;
          w_clr_press[w_sel] = w_press_pend[w_sel];
          w_clr_long[w_sel]  = ~w_press_pend[w_sel];
          rr_ptr_d = (w_sel == IW'(N_BTN - 1)) ? '0 : w_sel + IW'(1);
        end
      end
      ST_OFFER: begin
        if (evt_ready) evt_valid_d = 1'b0;
      end
      default: evt_valid_d = 1'b0;
    endcase
  end

  assign evt_valid = evt_valid_q;
  assign evt_id    = evt_id_q;
  assign evt_long  = evt_long_q;

endmodule : db_event_arbiter
`default_nettype wire

// File: tb/tb_db_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_db_event_arbiter
// Description : Self-checking bench for db_event_arbiter. A behavioural model
//               produces the expected events into a queue; a monitor checks
//               the DUT channel against it every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_db_event_arbiter;

  localparam int N  = 4;
  localparam int LC = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] btn_level = '0;
  logic         evt_ready = 1'b0;
  logic         overrun_clr = 1'b0;
  logic         evt_valid;
  logic [1:0]   evt_id;
  logic         evt_long;
  logic [N-1:0] overrun;

  always #5 clk = ~clk;

  db_event_arbiter #(
    .N_BTN       (N),
    .LONG_CYCLES (LC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_level   (btn_level),
    .evt_ready   (evt_ready),
    .evt_valid   (evt_valid),
    .evt_id      (evt_id),
    .evt_long    (evt_long),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct {
    int id;
    bit lng;
  } evt_t;

  evt_t exp_q[$];
  int   held[N];      // consecutive high cycles seen, capped at LC
  bit   prv[N];
  bit   pp[N];        // press waiting to be issued
  bit   lp[N];        // long press waiting to be issued
  bit   ov[N];
  bit   busy;         // an event is on offer
  int   rr;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      held[i] = 0; prv[i] = 0; pp[i] = 0; lp[i] = 0; ov[i] = 0;
    end
    busy = 0;
    rr   = 0;
    exp_q.delete();
  endtask

  task automatic model_step();
    bit rise[N];
    bit lhit[N];
    bit found;
    for (int i = 0; i < N; i++) begin
      rise[i] = btn_level[i] && !prv[i];
      lhit[i] = btn_level[i] && (held[i] == LC - 1);
    end
    if (!busy) begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        int i;
        i = (rr + k) % N;
        if (!found && (pp[i] || lp[i])) begin
          found = 1;
          exp_q.push_back('{i, !pp[i]});
          if (pp[i]) pp[i] = 0; else lp[i] = 0;
          rr   = (i + 1) % N;
          busy = 1;
        end
      end
    end else if (evt_ready) begin
      busy = 0;
    end
    if (overrun_clr) for (int i = 0; i < N; i++) ov[i] = 0;
    // Clears were applied above, so a full slot here means a lost event.
    for (int i = 0; i < N; i++) begin
      if (rise[i]) begin
        if (pp[i]) ov[i] = 1;
        pp[i] = 1;
      end
      if (lhit[i]) begin
        if (lp[i]) ov[i] = 1;
        lp[i] = 1;
      end
      held[i] = btn_level[i] ? ((held[i] < LC) ? held[i] + 1 : LC) : 0;
      prv[i]  = btn_level[i];
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step();
  end

  // ---------------- monitor ----------------
  int hs_cnt[N];
  int hs_long[N];

  always @(negedge clk) begin
    if (!rst) begin
      int ovm;
      ovm = 0;
      for (int i = 0; i < N; i++) if (ov[i]) ovm |= (1 << i);
      check("evt_valid", int'(evt_valid), int'(busy));
      check("overrun", int'(overrun), ovm);
      if (evt_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", 1, 0);
        end else begin
          check("evt_id", int'(evt_id), exp_q[0].id);
          check("evt_long", int'(evt_long), int'(exp_q[0].lng));
          if (evt_ready) begin
            void'(exp_q.pop_front());
            hs_cnt[evt_id]++;
            if (evt_long) hs_long[evt_id]++;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c0, c1, t0;
    bit seen;

    // Reset state
    tick(); tick();
    check("rst_valid", int'(evt_valid), 0);
    check("rst_id", int'(evt_id), 0);
    check("rst_long", int'(evt_long), 0);
    check("rst_overrun", int'(overrun), 0);
    rst = 1'b0;
    tick();

    // Short press on btn 1: event two edges after the rising edge
    evt_ready = 1'b1;
    btn_level = 4'b0010;
    tick();
    check("lat_edge_k", int'(evt_valid), 0);
    tick();
    check("lat_valid", int'(evt_valid), 1);
    check("lat_id", int'(evt_id), 1);
    check("lat_long", int'(evt_long), 0);
    tick();
    btn_level = 4'b0000;
    check("lat_one_cycle", int'(evt_valid), 0);
    repeat (12) tick();
    check("short_no_long", hs_long[1], 0);
    check("short_overrun", int'(overrun), 0);

    // Long hold on btn 2
    c0 = hs_cnt[2]; c1 = hs_long[2];
    btn_level = 4'b0100;
    repeat (20) tick();
    btn_level = 4'b0000;
    repeat (10) tick();
    check("hold_events", hs_cnt[2] - c0, 2);
    check("hold_long", hs_long[2] - c1, 1);

    // Simultaneous edges, two rounds
    for (int r = 0; r < 2; r++) begin
      btn_level = 4'b1111;
      tick();
      btn_level = 4'b0000;
      repeat (12) tick();
    end

    // Back-pressure: three presses on btn 3
    evt_ready = 1'b0;
    for (int p = 0; p < 3; p++) begin
      btn_level = 4'b1000;
      tick();
      btn_level = 4'b0000;
      tick();
    end
    tick(); tick();
    check("bp_overrun3", int'(overrun[3]), 1);
    check("bp_offer_id", int'(evt_id), 3);
    c0 = hs_cnt[3];
    evt_ready = 1'b1;
    repeat (8) tick();
    check("bp_delivered", hs_cnt[3] - c0, 2);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    check("ovr_clr", int'(overrun), 0);

    // Async reset in the middle of an offer with pend bits set
    evt_ready = 1'b0;
    btn_level = 4'b0011;
    tick();
    btn_level = 4'b0000;
    repeat (4) tick();
    check("pre_rst_valid", int'(evt_valid), 1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", int'(evt_valid), 0);
    check("arst_id", int'(evt_id), 0);
    check("arst_long", int'(evt_long), 0);
    check("arst_overrun", int'(overrun), 0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    t0 = hs_cnt[0] + hs_cnt[1] + hs_cnt[2] + hs_cnt[3];
    evt_ready = 1'b1;
    repeat (10) tick();
    check("post_rst_quiet", hs_cnt[0] + hs_cnt[1] + hs_cnt[2] + hs_cnt[3] - t0, 0);

    // New edge on btn 0 in the cycle its press bit is consumed
    evt_ready = 1'b0;
    btn_level = 4'b0010;
    tick();
    btn_level = 4'b0000;
    seen = 0;
    for (int w = 0; w < 10 && !seen; w++) begin
      tick();
      if (evt_valid) seen = 1;
    end
    check("coll_offer_seen", int'(seen), 1);
    btn_level = 4'b0001;
    tick();
    btn_level = 4'b0000;
    tick();
    c0 = hs_cnt[0];
    evt_ready = 1'b1;
    tick();
    btn_level = 4'b0001;
    tick();
    btn_level = 4'b0000;
    repeat (8) tick();
    check("coll_two_events", hs_cnt[0] - c0, 2);
    check("coll_no_overrun", int'(overrun[0]), 0);

    // Randomized traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      evt_ready   = ($urandom_range(0, 9) < 7);
      overrun_clr = ($urandom_range(0, 31) == 0);
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 5) == 0) btn_level[i] = ~btn_level[i];
      tick();
    end

    // Drain
    btn_level   = '0;
    overrun_clr = 1'b0;
    evt_ready   = 1'b1;
    repeat (24) tick();
    check("drain_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule : tb_db_event_arbiter
`default_nettype wire
